// File: rtl/drift_correction_scheduler_pkg.sv
// Shared types for the drift correction scheduler: clock/reset bundle plus
// scheduler state, direction encodings and default widths.
package common_p;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;
endpackage

package clks_alot_p;
    localparam int DEF_HALF_PERIOD_WIDTH = 16;
    localparam int DEF_LOCKOUT_WIDTH     = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        APPLY   = 3'd2,
        LOCKOUT = 3'd3,
        FAULT   = 3'd4
    } drift_sched_state_e;

    typedef enum logic {
        DRIFT_POS = 1'b0,
        DRIFT_NEG = 1'b1
    } drift_dir_e;
endpackage

// File: rtl/drift_correction_scheduler_lockout.sv
// Lockout edge counter: clear beats load beats decrement; decrement stops at zero.
module drift_lockout_counter
    import clks_alot_p::*;
#(
    parameter int LOCKOUT_WIDTH = DEF_LOCKOUT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     load_i,
    input  logic [LOCKOUT_WIDTH-1:0] load_val_i,
    input  logic                     dec_i,
    output logic [LOCKOUT_WIDTH-1:0] cnt_o,
    output logic                     zero_o
);
    localparam logic [LOCKOUT_WIDTH-1:0] LK_ONE = LOCKOUT_WIDTH'(1);

    logic [LOCKOUT_WIDTH-1:0] cnt_q;
    logic [LOCKOUT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LK_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/drift_correction_scheduler.sv
// Applies one-step half-period corrections on valid edge boundaries with lockout.
// Optional per-direction apply counters when DRIFT_SCHED_STATS_EN is defined.
module drift_correction_scheduler
    import clks_alot_p::*;
#(
    parameter int HALF_PERIOD_WIDTH = DEF_HALF_PERIOD_WIDTH,
    parameter int LOCKOUT_WIDTH     = DEF_LOCKOUT_WIDTH
) (
    input  common_p::clk_dom_s           sys_dom_i,
    input  logic                         sched_en_i,
    input  logic [HALF_PERIOD_WIDTH-1:0] base_half_period_i,
    input  logic [LOCKOUT_WIDTH-1:0]     lockout_edges_i,
    input  logic                         any_valid_edge_i,
    input  logic                         pos_drift_ready_i,
    input  logic                         neg_drift_ready_i,
    input  logic                         drift_acc_overflow_i,
    input  logic                         inverse_drift_violation_i,
    output logic                         drift_accepted_o,
    output logic [HALF_PERIOD_WIDTH-1:0] adj_half_period_o,
    output logic                         adj_valid_o,
    output logic                         fault_o,
    output logic                         resync_req_o,
    input  logic                         resync_ack_i,
`ifdef DRIFT_SCHED_STATS_EN
    output logic [15:0]                  pos_applied_cnt_o,
    output logic [15:0]                  neg_applied_cnt_o,
`endif
    output drift_sched_state_e           dbg_state_o,
    output logic [LOCKOUT_WIDTH-1:0]     dbg_lockout_cnt_o
);
    localparam logic [HALF_PERIOD_WIDTH-1:0] HP_ONE = HALF_PERIOD_WIDTH'(1);
    localparam logic [LOCKOUT_WIDTH-1:0]     LK_ONE = LOCKOUT_WIDTH'(1);

    logic clk;
    logic rst_n;
    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    drift_sched_state_e           state_q, state_d;
    drift_dir_e                   dir_q, dir_d;
    logic [HALF_PERIOD_WIDTH-1:0] adj_q, adj_d;
    logic [HALF_PERIOD_WIDTH-1:0] adj_calc;
    logic [LOCKOUT_WIDTH-1:0]     lock_cnt;
    logic                         lock_zero;
    logic                         lock_load;
    logic                         lock_dec;
    logic                         lock_clr;
    logic                         fault_in;
    logic                         dir_ready;
    logic                         adj_fire;

    assign fault_in  = drift_acc_overflow_i | inverse_drift_violation_i;
    assign dir_ready = (dir_q == DRIFT_POS) ? pos_drift_ready_i : neg_drift_ready_i;
    // A fault input seen during APPLY suppresses the correction in that same cycle.
    assign adj_fire  = (state_q == APPLY) && !fault_in;

    always_comb begin
        adj_calc = base_half_period_i;
        if (dir_q == DRIFT_POS) begin
            if (base_half_period_i != '1) begin
                adj_calc = base_half_period_i + HP_ONE;
            end
        end else begin
            if (base_half_period_i <= HP_ONE) begin
                adj_calc = HP_ONE;
            end else begin
                adj_calc = base_half_period_i - HP_ONE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        lock_load = 1'b0;
        lock_dec  = 1'b0;
        if (fault_in) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sched_en_i) begin
                        if (pos_drift_ready_i && neg_drift_ready_i) begin
                            state_d = FAULT;
                        end else if (pos_drift_ready_i) begin
                            state_d = ARMED;
                            dir_d   = DRIFT_POS;
                        end else if (neg_drift_ready_i) begin
                            state_d = ARMED;
                            dir_d   = DRIFT_NEG;
                        end
                    end
                end
                ARMED: begin
                    if (!sched_en_i || !dir_ready) begin
                        state_d = IDLE;
                    end else if (any_valid_edge_i) begin
                        state_d = APPLY;
                    end
                end
                APPLY: begin
                    lock_load = 1'b1;
                    state_d   = (lockout_edges_i == '0) ? IDLE : LOCKOUT;
                end
                LOCKOUT: begin
                    if (!sched_en_i || lock_zero) begin
                        state_d = IDLE;
                    end else if (any_valid_edge_i) begin
                        lock_dec = 1'b1;
                        if (lock_cnt == LK_ONE) begin
                            state_d = IDLE;
                        end
                    end
                end
                FAULT: begin
                    if (resync_ack_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The counter only survives while the FSM stays in (or enters) LOCKOUT.
    assign lock_clr = (state_d != LOCKOUT);
    assign adj_d    = adj_fire ? adj_calc : adj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DRIFT_POS;
            adj_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            adj_q   <= adj_d;
        end
    end

    drift_lockout_counter #(
        .LOCKOUT_WIDTH(LOCKOUT_WIDTH)
    ) u_lockout (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (lock_clr),
        .load_i     (lock_load),
        .load_val_i (lockout_edges_i),
        .dec_i      (lock_dec),
        .cnt_o      (lock_cnt),
        .zero_o     (lock_zero)
    );

    assign adj_half_period_o = adj_fire ? adj_calc : adj_q;
    assign adj_valid_o       = adj_fire;
    assign drift_accepted_o  = adj_fire;
    assign fault_o           = (state_q == FAULT);
    assign resync_req_o      = (state_q == FAULT);
    assign dbg_state_o       = state_q;
    assign dbg_lockout_cnt_o = lock_cnt;

`ifdef DRIFT_SCHED_STATS_EN
    logic [15:0] pos_cnt_q, pos_cnt_d;
    logic [15:0] neg_cnt_q, neg_cnt_d;

    always_comb begin
        pos_cnt_d = pos_cnt_q;
        neg_cnt_d = neg_cnt_q;
        if (adj_fire && (dir_q == DRIFT_POS) && (pos_cnt_q != 16'hFFFF)) begin
            pos_cnt_d = pos_cnt_q + 16'd1;
        end
        if (adj_fire && (dir_q == DRIFT_NEG) && (neg_cnt_q != 16'hFFFF)) begin
            neg_cnt_d = neg_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt_q <= '0;
            neg_cnt_q <= '0;
        end else begin
            pos_cnt_q <= pos_cnt_d;
            neg_cnt_q <= neg_cnt_d;
        end
    end

    assign pos_applied_cnt_o = pos_cnt_q;
    assign neg_applied_cnt_o = neg_cnt_q;
`endif
endmodule

// File: tb/tb_drift_correction_scheduler.sv
// Directed bench for drift_correction_scheduler: behavioural model compared every
// cycle, plus hand-computed literal checks of the key scenarios.
module tb_drift_correction_scheduler;
    import clks_alot_p::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sched_en = 1'b0;
    logic [15:0] base_hp = '0;
    logic [7:0]  lockout_edges = '0;
    logic        edge_p = 1'b0;
    logic        pos_rdy = 1'b0;
    logic        neg_rdy = 1'b0;
    logic        ovf = 1'b0;
    logic        inv = 1'b0;
    logic        ack = 1'b0;

    logic        drift_accepted;
    logic [15:0] adj_hp;
    logic        adj_valid;
    logic        fault;
    logic        resync_req;
    drift_sched_state_e dbg_state;
    logic [7:0]  dbg_cnt;
`ifdef DRIFT_SCHED_STATS_EN
    logic [15:0] pos_cnt;
    logic [15:0] neg_cnt;
`endif

    common_p::clk_dom_s sys_dom;
    assign sys_dom.clk   = clk;
    assign sys_dom.rst_n = rst_n;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    drift_correction_scheduler dut (
        .sys_dom_i                 (sys_dom),
        .sched_en_i                (sched_en),
        .base_half_period_i        (base_hp),
        .lockout_edges_i           (lockout_edges),
        .any_valid_edge_i          (edge_p),
        .pos_drift_ready_i         (pos_rdy),
        .neg_drift_ready_i         (neg_rdy),
        .drift_acc_overflow_i      (ovf),
        .inverse_drift_violation_i (inv),
        .drift_accepted_o          (drift_accepted),
        .adj_half_period_o         (adj_hp),
        .adj_valid_o               (adj_valid),
        .fault_o                   (fault),
        .resync_req_o              (resync_req),
        .resync_ack_i              (ack),
`ifdef DRIFT_SCHED_STATS_EN
        .pos_applied_cnt_o         (pos_cnt),
        .neg_applied_cnt_o         (neg_cnt),
`endif
        .dbg_state_o               (dbg_state),
        .dbg_lockout_cnt_o         (dbg_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // armed/apply/lock/faulted describe what the scheduler is doing in plain terms;
    // m_lock is the number of edges still to be swallowed.
    bit m_armed = 1'b0;
    bit m_apply = 1'b0;
    bit m_fault = 1'b0;
    int m_dir = 1;
    int m_lock = 0;
    int m_last_adj = 0;
    wire fin_w = ovf | inv;

    function automatic int sat_adj(input int b, input int d);
        int r;
        r = b + d;
        if (r > 65535) r = 65535;
        if (r < 1) r = 1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_armed <= 1'b0;
            m_apply <= 1'b0;
            m_fault <= 1'b0;
            m_dir <= 1;
            m_lock <= 0;
            m_last_adj <= 0;
        end else begin
            if (m_apply && !fin_w) m_last_adj <= sat_adj(int'(base_hp), m_dir);
            if (fin_w) begin
                m_fault <= 1'b1;
                m_armed <= 1'b0;
                m_apply <= 1'b0;
                m_lock <= 0;
            end else if (m_fault) begin
                if (ack) m_fault <= 1'b0;
            end else if (m_apply) begin
                m_apply <= 1'b0;
                m_lock <= int'(lockout_edges);
            end else if (m_armed) begin
                if (!sched_en || !((m_dir > 0) ? pos_rdy : neg_rdy)) m_armed <= 1'b0;
                else if (edge_p) begin
                    m_armed <= 1'b0;
                    m_apply <= 1'b1;
                end
            end else if (m_lock > 0) begin
                if (!sched_en) m_lock <= 0;
                else if (edge_p) m_lock <= m_lock - 1;
            end else if (sched_en) begin
                if (pos_rdy && neg_rdy) m_fault <= 1'b1;
                else if (pos_rdy) begin
                    m_armed <= 1'b1;
                    m_dir <= 1;
                end else if (neg_rdy) begin
                    m_armed <= 1'b1;
                    m_dir <= -1;
                end
            end
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    always @(negedge clk) begin
        logic        e_valid;
        logic [15:0] e_adj;
        logic [15:0] got_adj;
        e_valid = m_apply && !fin_w;
        e_adj = e_valid ? 16'(sat_adj(int'(base_hp), m_dir)) : 16'(m_last_adj);
        if (e_valid) exp_q.push_back(e_adj);
        checks++;
        if ({adj_valid, drift_accepted, adj_hp, fault, resync_req} !==
            {e_valid, e_valid, e_adj, m_fault, m_fault}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t: got v=%b acc=%b adj=%0d f=%b rs=%b, expected v=%b acc=%b adj=%0d f=%b rs=%b",
                     $time, adj_valid, drift_accepted, adj_hp, fault, resync_req,
                     e_valid, e_valid, e_adj, m_fault, m_fault);
        end
        if (adj_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected t=%0t: got adj=%0d, expected no correction", $time, adj_hp);
            end else begin
                got_adj = exp_q.pop_front();
                if (got_adj !== adj_hp) begin
                    errors++;
                    $display("FAIL sb_value t=%0t: got adj=%0d, expected %0d", $time, adj_hp, got_adj);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Single correction with lockout 0: ready, edge in ARMED, check APPLY cycle, back to IDLE.
    task automatic apply_one(input bit is_neg, input logic [15:0] exp_adj, input string tag);
        if (is_neg) neg_rdy = 1'b1; else pos_rdy = 1'b1;
        tick();
        edge_p = 1'b1;
        tick();
        edge_p = 1'b0;
        pos_rdy = 1'b0;
        neg_rdy = 1'b0;
        check({tag, "_valid"}, 32'(adj_valid), 1);
        check({tag, "_acc"}, 32'(drift_accepted), 1);
        check({tag, "_adj"}, 32'(adj_hp), 32'(exp_adj));
        tick();
        check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_hold"}, 32'(adj_hp), 32'(exp_adj));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tick(); tick(); tick();
        check("rst_valid", 32'(adj_valid), 0);
        check("rst_adj", 32'(adj_hp), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_resync", 32'(resync_req), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        sched_en = 1'b1;
        base_hp = 16'd100;
        lockout_edges = 8'd0;
        apply_one(1'b0, 16'd101, "pos100");
        base_hp = 16'd1;
        apply_one(1'b1, 16'd1, "neg_floor");
        base_hp = 16'hFFFF;
        apply_one(1'b0, 16'hFFFF, "pos_ceil");
        base_hp = 16'd50;
        apply_one(1'b1, 16'd49, "neg50");
        base_hp = 16'd0;
        apply_one(1'b0, 16'd1, "pos0");

        // edge coinciding with ARMED entry is ignored
        base_hp = 16'd300;
        pos_rdy = 1'b1;
        edge_p = 1'b1;
        tick();
        edge_p = 1'b0;
        tick();
        check("coin_no_apply", 32'(adj_valid), 0);
        check("coin_armed", 32'(dbg_state), 32'(ARMED));
        edge_p = 1'b1;
        tick();
        edge_p = 1'b0;
        pos_rdy = 1'b0;
        check("coin_apply_adj", 32'(adj_hp), 301);
        tick();

        // lockout 3 with ready held: applies on edge 0 and edge 4 only
        base_hp = 16'd200;
        lockout_edges = 8'd3;
        pos_rdy = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            edge_p = 1'b1;
            tick();
            edge_p = 1'b0;
            check($sformatf("lk_edge%0d_valid", k), 32'(adj_valid), (k == 0 || k == 4) ? 1 : 0);
            if (k == 0) begin
                tick();
                check("lk_cnt_loaded", 32'(dbg_cnt), 3);
                tick(); tick();
            end else begin
                tick(); tick(); tick();
            end
        end
        pos_rdy = 1'b0;
        sched_en = 1'b0;
        tick();
        check("en_drop_state", 32'(dbg_state), 32'(IDLE));
        check("en_drop_cnt", 32'(dbg_cnt), 0);
        sched_en = 1'b1;
        lockout_edges = 8'd0;
        tick();

        // ready drops while armed
        pos_rdy = 1'b1;
        tick();
        pos_rdy = 1'b0;
        edge_p = 1'b1;
        tick();
        edge_p = 1'b0;
        check("drop_idle", 32'(dbg_state), 32'(IDLE));
        tick();
        check("drop_no_apply", 32'(adj_valid), 0);

        // sched_en low while armed
        neg_rdy = 1'b1;
        tick();
        sched_en = 1'b0;
        tick();
        check("en_armed_idle", 32'(dbg_state), 32'(IDLE));
        neg_rdy = 1'b0;
        sched_en = 1'b1;
        tick();

        // both ready -> fault, sticky, held with sched_en low, cleared only with clean ack
        pos_rdy = 1'b1;
        neg_rdy = 1'b1;
        tick();
        pos_rdy = 1'b0;
        neg_rdy = 1'b0;
        check("both_fault", 32'(fault), 1);
        check("both_resync", 32'(resync_req), 1);
        check("both_no_acc", 32'(drift_accepted), 0);
        sched_en = 1'b0;
        tick();
        check("fault_held_en0", 32'(fault), 1);
        inv = 1'b1;
        ack = 1'b1;
        tick();
        check("fault_dirty_ack", 32'(fault), 1);
        inv = 1'b0;
        tick();
        ack = 1'b0;
        check("fault_cleared", 32'(fault), 0);
        check("resync_cleared", 32'(resync_req), 0);
        check("fault_to_idle", 32'(dbg_state), 32'(IDLE));
        sched_en = 1'b1;
        tick();

        // violation in the cycle the edge would trigger APPLY
        base_hp = 16'd100;
        pos_rdy = 1'b1;
        tick();
        edge_p = 1'b1;
        inv = 1'b1;
        tick();
        edge_p = 1'b0;
        inv = 1'b0;
        pos_rdy = 1'b0;
        check("inv_pre_no_valid", 32'(adj_valid), 0);
        check("inv_pre_fault", 32'(fault), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // violation during the APPLY cycle itself
        pos_rdy = 1'b1;
        tick();
        edge_p = 1'b1;
        tick();
        edge_p = 1'b0;
        pos_rdy = 1'b0;
        inv = 1'b1;
        #1;
        check("inv_apply_no_valid", 32'(adj_valid), 0);
        tick();
        inv = 1'b0;
        check("inv_apply_fault", 32'(fault), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // overflow from IDLE, scheduling disabled
        sched_en = 1'b0;
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        check("ovf_fault", 32'(fault), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        sched_en = 1'b1;

        // edge during APPLY does not decrement; then async reset in LOCKOUT
        base_hp = 16'd500;
        lockout_edges = 8'd2;
        pos_rdy = 1'b1;
        tick();
        edge_p = 1'b1;
        tick();
        check("rl_apply_adj", 32'(adj_hp), 501);
        pos_rdy = 1'b0;
        tick();
        edge_p = 1'b0;
        check("rl_lockout", 32'(dbg_state), 32'(LOCKOUT));
        check("rl_cnt2", 32'(dbg_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_adj", 32'(adj_hp), 0);
        check("arst_valid", 32'(adj_valid), 0);
        check("arst_fault", 32'(fault), 0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        check("arst_cnt", 32'(dbg_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_state", 32'(dbg_state), 32'(IDLE));
        check("post_rst_cnt", 32'(dbg_cnt), 0);
        tick();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/drift_correction_scheduler.md
Name: drift_correction_scheduler

Overview:
- Sequences drift corrections from drift_accumulator into the recovered-clock half-period generator.
- Accepts one pending positive or negative correction and waits for the next valid edge boundary. It then applies a one-step period adjustment (+1 or -1 count), acknowledges the accumulator, and enforces a programmable edge-count lockout between applications.
- Escalates accumulator overflow and inverse-drift violations into a sticky fault and a resync request.

Parameters:
- HALF_PERIOD_WIDTH, 16, width of the half-period count the adjustment applies to.
- LOCKOUT_WIDTH, 8, width of the lockout edge counter and its configuration input.

Ports:
- sys_dom_i  input  common_p::clk_dom_s  single clock domain bundle: .clk (rising edge) and .rst_n (asynchronous, active-low).
- sched_en_i  input  1  enables scheduling; when low the FSM holds IDLE and no corrections are applied.
- base_half_period_i  input  HALF_PERIOD_WIDTH  nominal half-period count.
- lockout_edges_i  input  LOCKOUT_WIDTH  minimum valid edges between applications; 0 means no lockout.
- any_valid_edge_i  input  1  single-cycle pulse, one per valid recovered edge.
- pos_drift_ready_i  input  1  accumulator requests a lengthening correction.
- neg_drift_ready_i  input  1  accumulator requests a shortening correction.
- drift_acc_overflow_i  input  1  accumulator overflow flag.
- inverse_drift_violation_i  input  1  accumulator direction-flip violation flag.
- drift_accepted_o  output  1  single-cycle acknowledge to the accumulator.
- adj_half_period_o  output  HALF_PERIOD_WIDTH  half-period for the generator's next load.
- adj_valid_o  output  1  single-cycle pulse; adj_half_period_o carries a correction.
- fault_o  output  1  sticky fault.
- resync_req_o  output  1  level request to the edge-recovery front end to resynchronise.
- resync_ack_i  input  1  front end acknowledges resync; clears the fault.

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE; all 1-bit outputs 0; adj_half_period_o = 0; lockout counter 0.
- IDLE:
  - With sched_en_i=1 and exactly one ready input high, latch the direction and go to ARMED.
  - With both ready inputs high in the same cycle, go to FAULT; no acknowledge is issued.
- ARMED: on any_valid_edge_i go to APPLY.
  - Direction is re-sampled on entry only; if the ready input drops before the edge, return to IDLE without applying.
- APPLY (one cycle):
  - adj_half_period_o = base_half_period_i + 1 for positive, - 1 for negative.
  - The result saturates at all-ones and at 1, never 0.
  - Assert adj_valid_o and drift_accepted_o in this same cycle.
  - Load the lockout counter with lockout_edges_i. Go to LOCKOUT, or to IDLE if lockout_edges_i = 0.
  - Latency from the triggering edge pulse to adj_valid_o is exactly 1 cycle.
- LOCKOUT: decrement on each any_valid_edge_i; go to IDLE when the counter reaches 0. Ready inputs are ignored here.
- FAULT:
  - Entered from any state on drift_acc_overflow_i or inverse_drift_violation_i; this has priority over every other transition, including APPLY.
  - fault_o=1 and resync_req_o=1 while in FAULT.
  - On resync_ack_i with both fault inputs low, clear fault_o and resync_req_o and go to IDLE.
- sched_en_i deasserted mid-operation: ARMED or LOCKOUT return to IDLE next cycle and the lockout counter clears. FAULT is held regardless of sched_en_i.
- Cycle coincidences:
  - An edge coinciding with ARMED entry does not trigger APPLY; a later edge is required.
  - An edge arriving in the APPLY cycle does not decrement the new lockout.
- adj_half_period_o holds its last value when adj_valid_o is low.

Optional Feature:
- Macro DRIFT_SCHED_STATS_EN.
- Defined: adds pos_applied_cnt_o and neg_applied_cnt_o outputs, 16 bits each, both reset to 0. Each increments on APPLY in its direction and saturates at 0xFFFF.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Add to clks_alot_p:
  - drift_sched_state_e enum {IDLE, ARMED, APPLY, LOCKOUT, FAULT}.
  - drift_dir_e {DRIFT_POS, DRIFT_NEG}.
  - Default widths HALF_PERIOD_WIDTH and LOCKOUT_WIDTH.
- One sub-module, drift_lockout_counter: load, edge decrement, clear, zero flag.
- Saturating adjust arithmetic stays inline.

Test Plan:
- Base 100, lockout 0; pos ready, then an edge -> next cycle adj_half_period_o=101, adj_valid_o=1, drift_accepted_o=1; back in IDLE.
- Base 1, neg ready, edge -> adj_half_period_o=1 (floor saturation); base 0xFFFF, pos ready, edge -> 0xFFFF.
- Lockout 3; pos ready is held continuously -> the second apply occurs only on the 4th edge after the first APPLY; ready is ignored for 3 edges.
- Pos and neg ready asserted in the same cycle -> FAULT: fault_o=1, resync_req_o=1, no drift_accepted_o. resync_ack_i with fault inputs low -> IDLE next cycle.
- inverse_drift_violation_i in the same cycle as APPLY would occur -> FAULT taken, adj_valid_o stays 0.
- rst_n asserted while in LOCKOUT with count 2 -> all outputs 0 immediately (asynchronous); after release, IDLE with lockout counter 0.
